// File: rtl/coin_pulse_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : coin_pulse_classifier                                            |
// | Brief   : Synchronises, debounces and width-classifies coin sensor pulses. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coin_pulse_classifier #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 4,
    parameter int SMALL_MIN   = 8,
    parameter int SMALL_MAX   = 15,
    parameter int LARGE_MIN   = 20,
    parameter int LARGE_MAX   = 31,
    parameter int MAX_W       = 63,
    parameter int COOL_CYC    = 8,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_raw,
    output logic       tok,
    output logic       tok_valid,
    output logic       err,
    output logic       jam,
    output logic [7:0] coin_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEB_RISE = 3'd1;
    localparam logic [2:0] S_MEASURE  = 3'd2;
    localparam logic [2:0] S_DEB_FALL = 3'd3;
    localparam logic [2:0] S_JAM      = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;

    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_cyc   = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] c_small_min = CNT_W'(SMALL_MIN);
    localparam logic [CNT_W-1:0] c_small_max = CNT_W'(SMALL_MAX);
    localparam logic [CNT_W-1:0] c_large_min = CNT_W'(LARGE_MIN);
    localparam logic [CNT_W-1:0] c_large_max = CNT_W'(LARGE_MAX);
    localparam logic [CNT_W-1:0] c_max_w     = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] c_cool_cyc  = CNT_W'(COOL_CYC);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   w_coin_s;
    logic                   w_settled;

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_width, w_width_nxt;
    logic [CNT_W-1:0] r_aux, w_aux_nxt;
    logic [CNT_W:0]   w_sum;
    logic             r_armed, w_armed_nxt;
    logic             w_ev_acc, w_ev_type, w_ev_err;

    logic             r_ev_acc, r_ev_type, r_ev_err, r_ev_jam;
    logic             r_tok, r_tok_valid, r_err, r_jam;
    logic [7:0]       r_coin_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], coin_raw};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_coin_s  = r_sync[SYNC_STAGES-1];
    // coin_s is only trustworthy once real samples have flushed the reset zeros
    assign w_settled = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_aux       <= '0;
            r_armed     <= 1'b0;
            r_ev_acc    <= 1'b0;
            r_ev_type   <= 1'b0;
            r_ev_err    <= 1'b0;
            r_ev_jam    <= 1'b0;
            r_tok       <= 1'b0;
            r_tok_valid <= 1'b0;
            r_err       <= 1'b0;
            r_jam       <= 1'b0;
            r_coin_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_width     <= w_width_nxt;
            r_aux       <= w_aux_nxt;
            r_armed     <= w_armed_nxt;
            r_ev_acc    <= w_ev_acc;
            r_ev_type   <= w_ev_type;
            r_ev_err    <= w_ev_err;
            r_ev_jam    <= (w_state_nxt == S_JAM);
            r_tok_valid <= r_ev_acc;
            r_err       <= r_ev_err;
            r_jam       <= r_ev_jam;
            if (r_ev_acc) begin
                r_tok      <= r_ev_type;
                r_coin_cnt <= r_coin_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_width_nxt = r_width;
        w_aux_nxt   = r_aux;
        w_armed_nxt = r_armed;
        w_ev_acc    = 1'b0;
        w_ev_type   = 1'b0;
        w_ev_err    = 1'b0;
        w_sum       = {1'b0, r_width} + {1'b0, r_aux} + (CNT_W+1)'(1);

        case (r_state)
            S_IDLE: begin
                // A pulse already in progress when reset lifted must not be accepted
                if (w_settled && !w_coin_s) begin
                    w_armed_nxt = 1'b1;
                end
                if (r_armed && w_coin_s) begin
                    w_state_nxt = S_DEB_RISE;
                    w_width_nxt = c_one;
                end
            end
            S_DEB_RISE: begin
                if (w_coin_s) begin
                    w_width_nxt = r_width + c_one;
                    if ((r_width + c_one) == c_deb_cyc) begin
                        w_state_nxt = S_MEASURE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MEASURE: begin
                if (w_coin_s) begin
                    w_width_nxt = r_width + c_one;
                    if ((r_width + c_one) == c_max_w) begin
                        w_state_nxt = S_JAM;
                        w_aux_nxt   = '0;
                        w_ev_err    = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_DEB_FALL;
                    w_aux_nxt   = c_one;
                end
            end
            S_DEB_FALL: begin
                if (w_coin_s) begin
                    // the low samples of a bounce count toward the width
                    if (w_sum >= {1'b0, c_max_w}) begin
                        w_width_nxt = c_max_w;
                        w_state_nxt = S_JAM;
                        w_aux_nxt   = '0;
                        w_ev_err    = 1'b1;
                    end else begin
                        w_width_nxt = w_sum[CNT_W-1:0];
                        w_state_nxt = S_MEASURE;
                    end
                end else begin
                    w_aux_nxt = r_aux + c_one;
                    if ((r_aux + c_one) == c_deb_cyc) begin
                        w_state_nxt = S_COOLDOWN;
                        w_aux_nxt   = '0;
                        if (r_width >= c_small_min && r_width <= c_small_max) begin
                            w_ev_acc  = 1'b1;
                            w_ev_type = 1'b0;
                        end else if (r_width >= c_large_min && r_width <= c_large_max) begin
                            w_ev_acc  = 1'b1;
                            w_ev_type = 1'b1;
                        end else begin
                            w_ev_err  = 1'b1;
                        end
                    end
                end
            end
            S_JAM: begin
                if (w_coin_s) begin
                    w_aux_nxt = '0;
                end else begin
                    w_aux_nxt = r_aux + c_one;
                    if ((r_aux + c_one) == c_deb_cyc) begin
                        w_state_nxt = S_COOLDOWN;
                        w_aux_nxt   = '0;
                    end
                end
            end
            S_COOLDOWN: begin
                w_aux_nxt = r_aux + c_one;
                if ((r_aux + c_one) == c_cool_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_aux_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_aux_nxt   = '0;
            end
        endcase
    end

    assign tok       = r_tok;
    assign tok_valid = r_tok_valid;
    assign err       = r_err;
    assign jam       = r_jam;
    assign coin_cnt  = r_coin_cnt;

endmodule
`default_nettype wire
